fc_classifier: RTL and testbench
================================

Name: fc_classifier

Overview:
- Parametrised fully-connected output layer with integrated argmax; successor to the current single-shot FC block.
- Accepts a frame of IN_VECTORS feature beats, each CHANNELS signed samples wide, over a valid/ready handshake.
- Computes NUM_CLASSES dot products plus bias in saturating accumulators, then runs a sequential argmax.
- Returns class index and winning score over a valid/ready output handshake. Sits after the last conv/pool stage.

Parameters:
- NUM_CLASSES, 10, number of output classes (>=2).
- IN_VECTORS, 16, feature beats per frame (>=1).
- CHANNELS, 3, signed samples per beat.
- DATA_BITS, 8, sample width (signed).
- W_BITS, 8, weight and bias width (signed).
- ACC_BITS, 24, accumulator and score width (signed); must be >= DATA_BITS+W_BITS+1.
- IDX_BITS, $clog2(NUM_CLASSES), class index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_val  in  1  beat valid.
- in_rdy  out  1  beat ready; a beat transfers on in_val&&in_rdy.
- data_in  in  CHANNELS*DATA_BITS  beat; channel ch occupies [ch*DATA_BITS +: DATA_BITS].
- bias  in  NUM_CLASSES*W_BITS  per-class bias; class c occupies [c*W_BITS +: W_BITS]; static during a frame.
- weight  in  NUM_CLASSES*IN_VECTORS*CHANNELS*W_BITS  weight for class c, beat k, channel ch occupies [((c*IN_VECTORS+k)*CHANNELS+ch)*W_BITS +: W_BITS]; static during a frame.
- out_val  out  1  result valid.
- out_rdy  in  1  result accepted on out_val&&out_rdy.
- decision  out  IDX_BITS  argmax class index.
- score  out  ACC_BITS  winning accumulator value.
- sat  out  1  some accumulator saturated during this frame.

Behaviour:
- Reset (async, immediate):
  - state=ACCUM, beat counter=0, accumulators=0.
  - in_rdy=1, out_val=0, decision=0, score=0, sat=0.
- Reset mid-frame discards all partial sums. The next accepted beat is beat 0 of a new frame.
- ACCUM state:
  - in_rdy=1.
  - On each transfer, for every class c: p = sum over ch of data[ch]*weight[c,k,ch], full-precision signed.
  - Beat k=0: acc[c] <= sat(sext(bias[c]) + p). Beats k>0: acc[c] <= sat(acc[c] + p).
  - sat() clamps to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1]. Any clamp sets an internal sticky flag. The flag is cleared on beat 0.
  - The beat counter wraps to 0 after beat IN_VECTORS-1, and the state moves to ARGMAX.
  - in_val low: nothing changes; gaps between beats are unlimited.
- ARGMAX state:
  - in_rdy=0; in_val is ignored.
  - First cycle: best_idx=0, best=acc[0], cmp=1.
  - Each cycle compares acc[cmp] against best as signed values; strictly greater replaces best. Ties keep the lower index.
  - After cmp=NUM_CLASSES-1 has been compared, go to HOLD.
- HOLD state:
  - out_val=1. decision, score and sat are registered and held stable until the transfer.
  - in_rdy=0.
  - On out_val&&out_rdy: out_val<=0, state=ACCUM, in_rdy<=1.
  - decision, score and sat keep their last values until the next result.
- Latency: out_val rises exactly NUM_CLASSES cycles after the clock edge that accepts the last beat (out_rdy independent).
- Throughput: one frame per IN_VECTORS + NUM_CLASSES + 1 cycles minimum, with out_rdy tied high.
- No combinational path from in_val to in_rdy, or from out_rdy to out_val.

Decomposition:
- Shared package fc_pkg holds:
  - the state enum (ACCUM, ARGMAX, HOLD);
  - the sat_add function, parametrised by ACC_BITS via localparam;
  - localparams for the slice-offset helpers for the weight and bias layout.
- Sub-module fc_mac_lane, instantiated NUM_CLASSES times in a generate loop. Each lane:
  - computes one class's CHANNELS-way dot product;
  - performs the bias-on-first-beat and saturating accumulate;
  - outputs acc and a per-lane saturation pulse.
- The top level owns the FSM, beat counter, argmax and output registers.

Test Plan:
- Weights all 0, bias[3]=5, other biases 0, 16 beats of random data -> decision=3, score=5, sat=0, out_val exactly 10 cycles after the last beat.
- data all channels=1 for 16 beats, every weight of class c = c, biases 0 -> score for class c = 48c; decision=9, score=432.
- Biases all 7, weights 0 -> tie across all classes -> decision=0, score=7. Second frame with bias[5]=-1, others -3 -> decision=5, score=-1.
- ACC_BITS=17, data=127, class-2 weights=127, others 0 -> class 2 clamps to 65535, sat=1, decision=2. Next clean frame -> sat=0.
- Hold out_rdy=0 for 5 cycles after out_val while driving in_val=1 -> in_rdy=0, outputs stable, no beats consumed. Raise out_rdy -> out_val drops next edge, in_rdy=1, next frame gives the correct result.
- Assert rst_n low after 7 beats with in_val bursty (every other cycle) -> outputs return to reset values immediately. A fresh 16-beat frame matches the reference model with no residue from the aborted frame.

Source files
------------

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module : fc_pkg
// Desc   : Shared types, saturating adder and bus-layout helpers for fc_classifier
// Rev    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ARGMAX = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Working width of the saturating adder; any ACC_BITS below this is clamped exactly.
    localparam int C_SAT_W = 64;

    typedef struct packed {
        logic                        clamped;
        logic signed [C_SAT_W-1:0]   value;
    } sat_res_t;

    function automatic sat_res_t sat_add(
        input logic signed [C_SAT_W-1:0] a,
        input logic signed [C_SAT_W-1:0] b,
        input int                        acc_bits
    );
        logic signed [C_SAT_W-1:0] sum;
        logic signed [C_SAT_W-1:0] hi;
        logic signed [C_SAT_W-1:0] lo;
        sat_res_t                  r;
        sum       = a + b;
        hi        = (C_SAT_W'(1) <<< (acc_bits - 1)) - C_SAT_W'(1);
        lo        = -hi - C_SAT_W'(1);
        r.clamped = 1'b0;
        r.value   = sum;
        if (sum > hi) begin
            r.value   = hi;
            r.clamped = 1'b1;
        end else if (sum < lo) begin
            r.value   = lo;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

    function automatic int w_offset(input int c, input int k, input int ch,
                                    input int in_vectors, input int channels, input int w_bits);
        return ((c * in_vectors + k) * channels + ch) * w_bits;
    endfunction

    function automatic int b_offset(input int c, input int w_bits);
        return c * w_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_if.sv
`default_nettype none
// ============================================================================
// Module : fc_if
// Desc   : Beat input, static coefficient and result handshake bundle
// Rev    : 1.0 - initial release
// ============================================================================
interface fc_if #(
    parameter int NUM_CLASSES = 10,
    parameter int IN_VECTORS  = 16,
    parameter int CHANNELS    = 3,
    parameter int DATA_BITS   = 8,
    parameter int W_BITS      = 8,
    parameter int ACC_BITS    = 24,
    parameter int IDX_BITS    = $clog2(NUM_CLASSES)
);
    logic                                         in_val;
    logic                                         in_rdy;
    logic [CHANNELS*DATA_BITS-1:0]                data_in;
    logic [NUM_CLASSES*W_BITS-1:0]                bias;
    logic [NUM_CLASSES*IN_VECTORS*CHANNELS*W_BITS-1:0] weight;
    logic                                         out_val;
    logic                                         out_rdy;
    logic [IDX_BITS-1:0]                          decision;
    logic [ACC_BITS-1:0]                          score;
    logic                                         sat;

    modport master (
        output in_val, data_in, bias, weight, out_rdy,
        input  in_rdy, out_val, decision, score, sat
    );

    modport slave (
        input  in_val, data_in, bias, weight, out_rdy,
        output in_rdy, out_val, decision, score, sat
    );
endinterface
`default_nettype wire

// File: rtl/fc_mac_lane.sv
`default_nettype none
// ============================================================================
// Module : fc_mac_lane
// Desc   : One class lane: per-beat dot product, bias on beat 0, saturating accumulate
// Rev    : 1.0 - initial release
// ============================================================================
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int DATA_BITS = 8,
    parameter int W_BITS    = 8,
    parameter int ACC_BITS  = 24
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          en,
    input  wire logic                          first,
    input  wire logic [CHANNELS*DATA_BITS-1:0] data,
    input  wire logic [CHANNELS*W_BITS-1:0]    weight,
    input  wire logic [W_BITS-1:0]             bias,
    output logic signed [ACC_BITS-1:0]         acc,
    output logic                               sat_pulse
);

    logic signed [C_SAT_W-1:0] w_dot;
    logic signed [C_SAT_W-1:0] w_base;
    sat_res_t                  w_res;
    logic                      w_unused_hi;

    always_comb begin
        w_dot = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_dot = w_dot + C_SAT_W'($signed(data[ch*DATA_BITS +: DATA_BITS]))
                          * C_SAT_W'($signed(weight[ch*W_BITS +: W_BITS]));
        end
    end

    // Beat 0 starts from the bias instead of the stale accumulator.
    assign w_base      = first ? C_SAT_W'($signed(bias)) : C_SAT_W'(acc);
    assign w_res       = sat_add(w_base, w_dot, ACC_BITS);
    assign sat_pulse   = en & w_res.clamped;
    assign w_unused_hi = ^w_res.value[C_SAT_W-1:ACC_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= w_res.value[ACC_BITS-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_classifier.sv
`default_nettype none
// ============================================================================
// Module : fc_classifier
// Desc   : Fully-connected output layer with saturating MAC lanes and sequential argmax
// Rev    : 1.0 - initial release
// ============================================================================
module fc_classifier
    import fc_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int IN_VECTORS  = 16,
    parameter int CHANNELS    = 3,
    parameter int DATA_BITS   = 8,
    parameter int W_BITS      = 8,
    parameter int ACC_BITS    = 24,
    parameter int IDX_BITS    = $clog2(NUM_CLASSES)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fc_if.slave       bus
);

    localparam int BEAT_W = (IN_VECTORS > 1) ? $clog2(IN_VECTORS) : 1;

    state_t                     r_state;
    logic [BEAT_W-1:0]          r_beat;
    logic                       r_in_rdy;
    logic                       r_out_val;
    logic                       r_sat_sticky;
    logic                       r_sat_out;
    logic [IDX_BITS-1:0]        r_cmp;
    logic [IDX_BITS-1:0]        r_best_idx;
    logic [IDX_BITS-1:0]        r_decision;
    logic signed [ACC_BITS-1:0] r_best;
    logic signed [ACC_BITS-1:0] r_score;

    logic signed [ACC_BITS-1:0] w_acc [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]     w_sat_pulse;
    logic                       w_xfer;
    logic                       w_first;
    logic                       w_last;
    logic signed [ACC_BITS-1:0] w_cand;
    logic                       w_take;
    logic signed [ACC_BITS-1:0] w_next_best;
    logic [IDX_BITS-1:0]        w_next_idx;

    assign w_xfer  = bus.in_val & r_in_rdy;
    assign w_first = (r_beat == '0);
    assign w_last  = (r_beat == BEAT_W'(IN_VECTORS - 1));

    generate
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
            logic [CHANNELS*W_BITS-1:0] w_lane_w;
            assign w_lane_w = bus.weight[w_offset(c, int'(r_beat), 0, IN_VECTORS, CHANNELS, W_BITS)
                                         +: CHANNELS*W_BITS];
            fc_mac_lane #(
                .CHANNELS  (CHANNELS),
                .DATA_BITS (DATA_BITS),
                .W_BITS    (W_BITS),
                .ACC_BITS  (ACC_BITS)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (w_xfer),
                .first     (w_first),
                .data      (bus.data_in),
                .weight    (w_lane_w),
                .bias      (bus.bias[b_offset(c, W_BITS) +: W_BITS]),
                .acc       (w_acc[c]),
                .sat_pulse (w_sat_pulse[c])
            );
        end
    endgenerate

    // Index 0 always loads; later indices replace only when strictly greater.
    assign w_cand      = w_acc[r_cmp];
    assign w_take      = (r_cmp == '0) || (w_cand > r_best);
    assign w_next_best = w_take ? w_cand : r_best;
    assign w_next_idx  = w_take ? r_cmp : r_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ACCUM;
            r_beat       <= '0;
            r_in_rdy     <= 1'b1;
            r_out_val    <= 1'b0;
            r_sat_sticky <= 1'b0;
            r_sat_out    <= 1'b0;
            r_cmp        <= '0;
            r_best_idx   <= '0;
            r_decision   <= '0;
            r_best       <= '0;
            r_score      <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_xfer) begin
                        r_sat_sticky <= (w_first ? 1'b0 : r_sat_sticky) | (|w_sat_pulse);
                        if (w_last) begin
                            r_beat   <= '0;
                            r_cmp    <= '0;
                            r_in_rdy <= 1'b0;
                            r_state  <= ST_ARGMAX;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_ARGMAX: begin
                    r_best     <= w_next_best;
                    r_best_idx <= w_next_idx;
                    if (r_cmp == IDX_BITS'(NUM_CLASSES - 1)) begin
                        r_decision <= w_next_idx;
                        r_score    <= w_next_best;
                        r_sat_out  <= r_sat_sticky;
                        r_out_val  <= 1'b1;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_cmp <= r_cmp + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_rdy) begin
                        r_out_val <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_state   <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.in_rdy   = r_in_rdy;
    assign bus.out_val  = r_out_val;
    assign bus.decision = r_decision;
    assign bus.score    = r_score;
    assign bus.sat      = r_sat_out;

endmodule
`default_nettype wire

// File: tb/tb_fc_classifier.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_classifier
// Desc   : Scoreboard bench; two lockstep DUTs (ACC_BITS 24 and 17) share one stimulus
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fc_classifier;

    localparam int NC = 10;
    localparam int IV = 16;
    localparam int CH = 3;
    localparam int AA = 24;
    localparam int AB = 17;

    logic clk;
    logic rst_n;
    logic in_val;
    logic out_rdy;
    logic [CH*8-1:0]       data_in;
    logic [NC*8-1:0]       bias_v;
    logic [NC*IV*CH*8-1:0] weight_v;

    int cyc = 0;
    int last_cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic signed [7:0] fd [IV][CH];
    logic [52:0] exp_q [$];

    fc_if #(.ACC_BITS(AA)) bus_a ();
    fc_if #(.ACC_BITS(AB)) bus_b ();

    assign bus_a.in_val  = in_val;
    assign bus_a.out_rdy = out_rdy;
    assign bus_a.data_in = data_in;
    assign bus_a.bias    = bias_v;
    assign bus_a.weight  = weight_v;
    assign bus_b.in_val  = in_val;
    assign bus_b.out_rdy = out_rdy;
    assign bus_b.data_in = data_in;
    assign bus_b.bias    = bias_v;
    assign bus_b.weight  = weight_v;

    fc_classifier #(.ACC_BITS(AA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fc_classifier #(.ACC_BITS(AB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

    // Reference model over the stored frame, with the given accumulator width.
    function automatic void model_cfg(input int ab, output int d, output longint s, output bit st);
        longint acc [NC];
        longint hi, lo, p, a;
        hi = (longint'(1) <<< (ab - 1)) - 1;
        lo = -hi - 1;
        st = 1'b0;
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < IV; k++) begin
                p = 0;
                for (int ch = 0; ch < CH; ch++)
                    p += longint'($signed(weight_v[((c*IV+k)*CH+ch)*8 +: 8])) * longint'(fd[k][ch]);
                a = (k == 0) ? longint'($signed(bias_v[c*8 +: 8])) + p : acc[c] + p;
                if (a > hi) begin a = hi; st = 1'b1; end
                if (a < lo) begin a = lo; st = 1'b1; end
                acc[c] = a;
            end
        end
        d = 0;
        s = acc[0];
        for (int c = 1; c < NC; c++)
            if (acc[c] > s) begin d = c; s = acc[c]; end
    endfunction

    function automatic logic [52:0] predict();
        int da, db;
        longint sa, sb;
        bit ta, tb;
        model_cfg(AA, da, sa, ta);
        model_cfg(AB, db, sb, tb);
        return {2'b11, 4'(da), 24'(sa), ta, 4'(db), 17'(sb), tb};
    endfunction

    function automatic logic [52:0] observe();
        return {bus_a.out_val, bus_b.out_val, bus_a.decision, bus_a.score, bus_a.sat,
                bus_b.decision, bus_b.score, bus_b.sat};
    endfunction

    function automatic void set_weights(input int mode);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < IV; k++)
                for (int ch = 0; ch < CH; ch++)
                    weight_v[((c*IV+k)*CH+ch)*8 +: 8] =
                        (mode == 0) ? 8'd0 : (mode == 1) ? 8'(c) :
                        (mode == 2) ? ((c == 2) ? 8'd127 : 8'd0) : 8'($urandom);
    endfunction

    function automatic void set_data(input int mode);
        for (int k = 0; k < IV; k++)
            for (int ch = 0; ch < CH; ch++)
                fd[k][ch] = (mode == 1) ? 8'sd1 : (mode == 2) ? 8'sd127 : 8'($urandom);
    endfunction

    task automatic send_frame(input int nbeats, input bit bursty);
        for (int k = 0; k < nbeats; k++) begin
            int n;
            if (bursty && k > 0) begin
                in_val = 1'b0;
                @(posedge clk); #1;
            end
            in_val = 1'b1;
            for (int ch = 0; ch < CH; ch++) data_in[ch*8 +: 8] = fd[k][ch];
            n = 0;
            while (!bus_a.in_rdy && n < 100) begin @(posedge clk); #1; n++; end
            if (!bus_a.in_rdy) begin
                n_cmp++; n_err++;
                $display("FAIL in_rdy_wait: in_rdy=%0b after %0d cycles, need 1", bus_a.in_rdy, n);
            end
            @(posedge clk); #1;
        end
        in_val = 1'b0;
        last_cyc = cyc;
        if (nbeats == IV) exp_q.push_back(predict());
    endtask

    task automatic wait_out(output int lat, output bit to);
        int n;
        n = 0;
        while (!bus_a.out_val && n < 100) begin @(posedge clk); #1; n++; end
        to  = !bus_a.out_val;
        lat = cyc - last_cyc;
    endtask

    task automatic accept();
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus_a.in_rdy, bus_b.in_rdy, observe()} !== {2'b11, 53'd0}) begin
            n_err++;
            $display("FAIL reset_held: got %h, need %h", {bus_a.in_rdy, bus_b.in_rdy, observe()}, {2'b11, 53'd0});
        end
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if ({bus_a.in_rdy, bus_b.in_rdy, observe()} !== {2'b11, 53'd0}) begin
            n_err++;
            $display("FAIL reset_idle: got %h, need %h", {bus_a.in_rdy, bus_b.in_rdy, observe()}, {2'b11, 53'd0});
        end
    endtask

    task automatic test_bias_only();
        int lat; bit to; logic [52:0] e;
        set_weights(0);
        bias_v = '0;
        bias_v[3*8 +: 8] = 8'd5;
        set_data(0);
        send_frame(IV, 1'b0);
        wait_out(lat, to);
        n_cmp++;
        if (to || lat != NC) begin
            n_err++; $display("FAIL bias_latency: got %0d cycles (timeout=%0b), need %0d", lat, to, NC);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (observe() !== e) begin n_err++; $display("FAIL bias_result: got %h, need %h", observe(), e); end
        n_cmp++;
        if ({bus_a.decision, bus_a.score, bus_a.sat} !== {4'd3, 24'd5, 1'b0}) begin
            n_err++; $display("FAIL bias_const: got dec=%0d score=%0d sat=%0b, need 3/5/0",
                              bus_a.decision, bus_a.score, bus_a.sat);
        end
        accept();
    endtask

    task automatic test_ramp();
        int lat; bit to; logic [52:0] e;
        set_weights(1);
        bias_v = '0;
        set_data(1);
        send_frame(IV, 1'b1);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || observe() !== e) begin n_err++; $display("FAIL ramp_result: got %h, need %h", observe(), e); end
        n_cmp++;
        if ({bus_a.decision, bus_a.score, bus_b.score} !== {4'd9, 24'd432, 17'd432}) begin
            n_err++; $display("FAIL ramp_const: got dec=%0d score=%0d, need 9/432", bus_a.decision, bus_a.score);
        end
        accept();
    endtask

    task automatic test_ties();
        int lat; bit to; logic [52:0] e;
        set_weights(0);
        for (int c = 0; c < NC; c++) bias_v[c*8 +: 8] = 8'd7;
        set_data(0);
        send_frame(IV, 1'b0);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || {bus_a.decision, bus_a.score} !== {4'd0, 24'd7} || observe() !== e) begin
            n_err++; $display("FAIL tie_all: got %h, need %h (dec 0 score 7)", observe(), e);
        end
        accept();
        for (int c = 0; c < NC; c++) bias_v[c*8 +: 8] = (c == 5) ? 8'hFF : 8'hFD;
        set_data(0);
        send_frame(IV, 1'b1);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || bus_a.decision !== 4'd5 || $signed(bus_a.score) !== -1 || observe() !== e) begin
            n_err++; $display("FAIL tie_neg: got %h, need %h (dec 5 score -1)", observe(), e);
        end
        accept();
    endtask

    task automatic test_saturation();
        int lat; bit to; logic [52:0] e;
        set_weights(2);
        bias_v = '0;
        set_data(2);
        send_frame(IV, 1'b0);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || observe() !== e) begin n_err++; $display("FAIL sat_result: got %h, need %h", observe(), e); end
        n_cmp++;
        if ({bus_b.decision, bus_b.score, bus_b.sat, bus_a.sat} !== {4'd2, 17'd65535, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL sat_clamp: got dec=%0d score=%0d sat=%0b wide_sat=%0b, need 2/65535/1/0",
                              bus_b.decision, bus_b.score, bus_b.sat, bus_a.sat);
        end
        accept();
        set_weights(1);
        set_data(1);
        send_frame(IV, 1'b0);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || bus_b.sat !== 1'b0 || observe() !== e) begin
            n_err++; $display("FAIL sat_clear: got %h sat=%0b, need %h sat=0", observe(), bus_b.sat, e);
        end
        accept();
    endtask

    task automatic test_backpressure();
        int lat; bit to; logic [52:0] e, snap;
        set_weights(3);
        for (int c = 0; c < NC; c++) bias_v[c*8 +: 8] = 8'($urandom);
        set_data(0);
        send_frame(IV, 1'b0);
        wait_out(lat, to);
        e = exp_q.pop_front();
        snap = observe();
        n_cmp++;
        if (to || snap !== e) begin n_err++; $display("FAIL bp_result: got %h, need %h", snap, e); end
        in_val = 1'b1;
        data_in = 24'h7F7F7F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus_a.in_rdy, bus_b.in_rdy, observe()} !== {2'b00, e}) begin
                n_err++; $display("FAIL bp_hold%0d: got %h, need %h", i, {bus_a.in_rdy, bus_b.in_rdy, observe()}, {2'b00, e});
            end
        end
        accept();
        in_val = 1'b0;
        n_cmp++;
        if ({bus_a.out_val, bus_b.out_val, bus_a.in_rdy, bus_b.in_rdy} !== 4'b0011) begin
            n_err++; $display("FAIL bp_release: got %b, need 0011",
                              {bus_a.out_val, bus_b.out_val, bus_a.in_rdy, bus_b.in_rdy});
        end
        set_data(0);
        send_frame(IV, 1'b1);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || lat != NC || observe() !== e) begin
            n_err++; $display("FAIL bp_next: got %h lat=%0d, need %h lat=%0d", observe(), lat, e, NC);
        end
        accept();
    endtask

    task automatic test_reset_midframe();
        int lat; bit to; logic [52:0] e;
        set_data(0);
        send_frame(7, 1'b1);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({bus_a.in_rdy, bus_b.in_rdy, observe()} !== {2'b11, 53'd0}) begin
            n_err++; $display("FAIL midreset_outputs: got %h, need %h", {bus_a.in_rdy, bus_b.in_rdy, observe()}, {2'b11, 53'd0});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_data(0);
        send_frame(IV, 1'b0);
        wait_out(lat, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to || observe() !== e) begin n_err++; $display("FAIL midreset_fresh: got %h, need %h", observe(), e); end
        accept();
    endtask

    task automatic test_back_to_back();
        int lat; bit to; logic [52:0] e;
        for (int f = 0; f < 4; f++) begin
            set_weights(3);
            for (int c = 0; c < NC; c++) bias_v[c*8 +: 8] = 8'($urandom);
            set_data(0);
            send_frame(IV, f[0]);
            wait_out(lat, to);
            e = exp_q.pop_front();
            n_cmp++;
            if (to || lat != NC || observe() !== e) begin
                n_err++; $display("FAIL b2b_frame%0d: got %h lat=%0d, need %h lat=%0d", f, observe(), lat, e, NC);
            end
            accept();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_val   = 1'b0;
        out_rdy  = 1'b0;
        data_in  = '0;
        bias_v   = '0;
        weight_v = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_bias_only();
        test_ramp();
        test_ties();
        test_saturation();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
